// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, 11 clocks per block.
// Ports:
//   iClk, iRstn  - clock, asynchronous active-low reset
//   iStart       - start request, honoured only when idle
//   iCipher      - ciphertext block, captured on the accepting edge
//   oKeyIdx      - round-key index requested this cycle (10 when idle)
//   iRoundKey    - round key for oKeyIdx, valid combinationally in the same cycle
//   oBusy        - block in flight
//   oDone        - one-cycle completion pulse
//   oPlain       - plaintext, held until the next completion
module aes_inv_cipher_iter (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         iStart,
  input  logic [127:0] iCipher,
  output logic [3:0]   oKeyIdx,
  input  logic [127:0] iRoundKey,
  output logic         oBusy,
  output logic         oDone,
  output logic [127:0] oPlain
);

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_KEY  = IDX_W'(10);
  localparam logic [IDX_W-1:0] FIRST_RND = IDX_W'(9);

  // FIPS-197 inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic {IDLE, ROUND} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   rnd_q, rnd_d;
  logic [IDX_W-1:0]   key_idx_q, key_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BLOCK_W-1:0] plain_q, plain_d;
  logic [BLOCK_W-1:0] round_t;

  function automatic logic [7:0] inv_sbox(input logic [7:0] idx);
    return INV_SBOX[{~idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // One column: x2/x4/x8 chains give 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    end
    return o;
  endfunction

  // State register.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rnd_q     <= '0;
      key_idx_q <= LAST_KEY;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      plain_q   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      key_idx_q <= key_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      plain_q   <= plain_d;
    end
  end

  // Next-state and round datapath; key index is registered one round ahead.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    key_idx_d = key_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    plain_d   = plain_q;
    round_t   = inv_sub_bytes(inv_shift_rows(state_q)) ^ iRoundKey;

    case (fsm_q)
      IDLE: begin
        if (iStart) begin
          state_d   = iCipher ^ iRoundKey;
          rnd_d     = FIRST_RND;
          key_idx_d = FIRST_RND;
          busy_d    = 1'b1;
          fsm_d     = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q != '0) begin
          state_d   = inv_mix_columns(round_t);
          rnd_d     = rnd_q - IDX_W'(1);
          key_idx_d = rnd_q - IDX_W'(1);
        end else begin
          plain_d   = round_t;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          key_idx_d = LAST_KEY;
          fsm_d     = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign oKeyIdx = key_idx_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oPlain  = plain_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter. Reference is a byte-level forward AES-128
// (S-box derived from GF(2^8) inversion + affine map); expected plaintexts are
// the plaintexts that the model encrypted into the ciphertext fed to the DUT.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] cipher;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         busy;
  logic         done;
  logic [127:0] plain;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk [11];

  aes_inv_cipher_iter dut (
    .iClk     (clk),
    .iRstn    (rst_n),
    .iStart   (start),
    .iCipher  (cipher),
    .oKeyIdx  (key_idx),
    .iRoundKey(round_key),
    .oBusy    (busy),
    .oDone    (done),
    .oPlain   (plain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read key store.
  assign round_key = (key_idx <= 4'd10) ? rk[key_idx] : '0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_tables();
    logic [7:0] inv;
    logic [7:0] o;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox_t[x] = o;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [7:0] wb [176];
    logic [7:0] t  [4];
    logic [7:0] rcon;
    logic [7:0] tmp;
    rcon = 8'h01;
    for (int j = 0; j < 16; j++) wb[j] = key[8*j +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int k = 0; k < 4; k++) t[k] = wb[4*(i-1)+k];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sbox_t[t[1]] ^ rcon;
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[tmp];
        rcon = gmul(rcon, 8'h02);
      end
      for (int k = 0; k < 4; k++) wb[4*i+k] = wb[4*(i-4)+k] ^ t[k];
    end
    for (int r = 0; r < 11; r++) begin
      for (int j = 0; j < 16; j++) rk[r][8*j +: 8] = wb[16*r+j];
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] n [16];
    logic [127:0] out;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[0][8*i +: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) n[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c+0] = gmul(n[4*c],8'h02) ^ gmul(n[4*c+1],8'h03) ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+1] = n[4*c] ^ gmul(n[4*c+1],8'h02) ^ gmul(n[4*c+2],8'h03) ^ n[4*c+3];
          s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gmul(n[4*c+2],8'h02) ^ gmul(n[4*c+3],8'h03);
          s[4*c+3] = gmul(n[4*c],8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gmul(n[4*c+3],8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = n[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][8*i +: 8];
    end
    for (int i = 0; i < 16; i++) out[8*i +: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cipher = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (plain !== 128'h0) begin errors++; $display("FAIL reset_plain got=%h exp=0", plain); end
    checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL reset_keyidx got=%0d exp=10", key_idx); end
    rst_n = 1'b1;
    step();
    checks++; if (key_idx !== 4'd10 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle keyidx=%0d busy=%b exp 10/0", key_idx, busy);
    end
  endtask

  task automatic test_fips_c1();
    logic [3:0] exp_idx;
    expand_key(C1_KEY);
    step();
    checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL c1_idle_keyidx got=%0d exp=10", key_idx); end
    start = 1'b1; cipher = C1_CT;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (cyc == 1) begin start = 1'b0; cipher = rand128(); end
      exp_idx = (cyc <= 10) ? 4'(10 - cyc) : 4'd10;
      checks++; if (key_idx !== exp_idx) begin errors++; $display("FAIL c1_keyidx cyc=%0d got=%0d exp=%0d", cyc, key_idx, exp_idx); end
      checks++; if (done !== (cyc == 11)) begin errors++; $display("FAIL c1_done cyc=%0d got=%b exp=%b", cyc, done, cyc == 11); end
      checks++; if (busy !== (cyc <= 10)) begin errors++; $display("FAIL c1_busy cyc=%0d got=%b exp=%b", cyc, busy, cyc <= 10); end
      if (cyc >= 11) begin
        checks++; if (plain !== C1_PT) begin errors++; $display("FAIL c1_plain cyc=%0d got=%h exp=%h", cyc, plain, C1_PT); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt [3];
    logic [127:0] ct [3];
    logic [3:0]   exp_idx;
    logic         exp_done;
    logic         exp_busy;
    expand_key(C1_KEY);
    pt[0] = C1_PT; ct[0] = C1_CT;
    for (int b = 1; b < 3; b++) begin pt[b] = rand128(); ct[b] = encrypt(pt[b]); end
    step();
    start = 1'b1; cipher = ct[0];
    for (int cyc = 1; cyc <= 34; cyc++) begin
      step();
      if (cyc == 11) cipher = ct[1];
      if (cyc == 22) cipher = ct[2];
      if (cyc == 33) start = 1'b0;
      exp_done = (cyc == 11) || (cyc == 22) || (cyc == 33);
      exp_busy = (cyc <= 32) && (cyc != 11) && (cyc != 22);
      exp_idx  = (cyc % 11 == 0 || cyc > 33) ? 4'd10 : 4'(10 - cyc % 11);
      checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      checks++; if (key_idx !== exp_idx) begin errors++; $display("FAIL b2b_keyidx cyc=%0d got=%0d exp=%0d", cyc, key_idx, exp_idx); end
      if (exp_done) begin
        checks++; if (plain !== pt[cyc/11 - 1]) begin
          errors++; $display("FAIL b2b_plain cyc=%0d got=%h exp=%h", cyc, plain, pt[cyc/11 - 1]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    expand_key(C1_KEY);
    step();
    start = 1'b1; cipher = C1_CT;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      if (cyc == 1) start = 1'b0;
      if (cyc == 5) begin start = 1'b1; cipher = rand128(); end
      if (cyc == 6) start = 1'b0;
      checks++; if (done !== (cyc == 11)) begin errors++; $display("FAIL busy_start_done cyc=%0d got=%b exp=%b", cyc, done, cyc == 11); end
      if (cyc >= 11) begin
        checks++; if (plain !== C1_PT) begin errors++; $display("FAIL busy_start_plain cyc=%0d got=%h exp=%h", cyc, plain, C1_PT); end
      end
    end
  endtask

  task automatic test_mid_reset();
    expand_key(C1_KEY);
    step();
    start = 1'b1; cipher = C1_CT;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      step();
      if (cyc == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (plain !== 128'h0) begin errors++; $display("FAIL midrst_plain got=%h exp=0", plain); end
    checks++; if (key_idx !== 4'd10) begin errors++; $display("FAIL midrst_keyidx got=%0d exp=10", key_idx); end
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet cyc=%0d done=%b busy=%b exp 0/0", cyc, done, busy);
      end
    end
    start = 1'b1; cipher = C1_CT;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      step();
      if (cyc == 1) start = 1'b0;
      checks++; if (done !== (cyc == 11)) begin errors++; $display("FAIL midrst_restart_done cyc=%0d got=%b exp=%b", cyc, done, cyc == 11); end
    end
    checks++; if (plain !== C1_PT) begin errors++; $display("FAIL midrst_restart_plain got=%h exp=%h", plain, C1_PT); end
  endtask

  task automatic test_round_trip();
    logic [127:0] key;
    logic [127:0] pt;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      key = rand128();
      pt  = rand128();
      expand_key(key);
      step();
      start = 1'b1; cipher = encrypt(pt);
      lat = 0;
      do begin
        step();
        start = 1'b0;
        lat++;
      end while (done !== 1'b1 && lat < 20);
      checks++; if (lat != 11) begin errors++; $display("FAIL rt_latency n=%0d got=%0d exp=11", n, lat); end
      checks++; if (plain !== pt) begin errors++; $display("FAIL rt_plain n=%0d got=%h exp=%h", n, plain, pt); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cipher = '0;
    for (int r = 0; r < 11; r++) rk[r] = '0;
    init_tables();
    test_reset();
    test_fips_c1();
    test_back_to_back();
    test_start_while_busy();
    test_mid_reset();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
